// File: rtl/arya_exec_pkg.sv
// Shared definitions for the Arya execute stage: ALU opcodes, multiplier
// FSM state encoding and the shift-amount width helper.
package arya_exec_pkg;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_NOT  = 4'd5;
   localparam logic [3:0] ALU_SLL  = 4'd6;
   localparam logic [3:0] ALU_SRL  = 4'd7;
   localparam logic [3:0] ALU_SRA  = 4'd8;
   localparam logic [3:0] ALU_SLT  = 4'd9;
   localparam logic [3:0] ALU_SLTU = 4'd10;
   localparam logic [3:0] ALU_PASS = 4'd11;
   localparam logic [3:0] ALU_MUL  = 4'd12;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } mul_state_t;

   // Number of operand-B bits that form a shift amount for a given width.
   function automatic int shamt_width(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/mul_iter.sv
// Radix-2 iterative shift-add multiplier: one partial product per cycle,
// WIDTH cycles in BUSY, product held for one cycle in DONE.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for i_start; operands latched on start
//   BUSY    | one shift-add step per cycle, r_count = step index
//   DONE    | r_acc holds the low WIDTH bits of the product for one cycle
module mul_iter
   import arya_exec_pkg::*;
#(
   parameter int WIDTH = 64
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_product
);

   localparam int CW = $clog2(WIDTH);

   mul_state_t       r_state;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic             r_busy;
   logic             r_done;

   // Sequencer and datapath: abort drops any work in progress back to IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_count  <= '0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_mcand  <= i_a;
                  r_mplier <= i_b;
                  r_acc    <= '0;
                  r_count  <= '0;
                  r_state  <= ST_BUSY;
                  r_busy   <= 1'b1;
                  r_done   <= 1'b0;
               end
            end
            ST_BUSY: begin
               if (i_abort) begin
                  r_state <= ST_IDLE;
                  r_count <= '0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b0;
               end else begin
                  if (r_mplier[0]) begin
                     r_acc <= r_acc + r_mcand;
                  end
                  r_mcand  <= r_mcand << 1;
                  r_mplier <= r_mplier >> 1;
                  r_count  <= r_count + 1'b1;
                  if (r_count == CW'(WIDTH - 1)) begin
                     r_state <= ST_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_count <= '0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy    = r_busy;
   assign o_done    = r_done;
   assign o_product = r_acc;

endmodule

// File: rtl/execute_stage.sv
// Arya execute stage: operand forwarding, single-cycle ALU and the
// execute/write-back output register. Building with EXEC_MUL_EN defined adds
// the iterative multiplier for opcode 12 and the upstream stall it needs.
module execute_stage
   import arya_exec_pkg::*;
#(
   parameter int DATAPATH_WIDTH     = 64,
   parameter int REGFILE_ADDR_WIDTH = 5,
   parameter int INST_ADDR_WIDTH    = 9
)(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          flush,
   input  logic [INST_ADDR_WIDTH-1:0]    pc_in,
   input  logic [DATAPATH_WIDTH-1:0]     R1_data_in,
   input  logic [DATAPATH_WIDTH-1:0]     R2_data_in,
   input  logic [REGFILE_ADDR_WIDTH-1:0] R1_addr_in,
   input  logic [REGFILE_ADDR_WIDTH-1:0] R2_addr_in,
   input  logic [REGFILE_ADDR_WIDTH-1:0] WR_addr_in,
   input  logic                          WR_en_in,
   input  logic [3:0]                    alu_ctrl_in,
   input  logic                          wb_wr_en,
   input  logic [REGFILE_ADDR_WIDTH-1:0] wb_wr_addr,
   input  logic [DATAPATH_WIDTH-1:0]     wb_wr_data,
   output logic                          stall_out,
   output logic [INST_ADDR_WIDTH-1:0]    pc_out,
   output logic [DATAPATH_WIDTH-1:0]     result_out,
   output logic [REGFILE_ADDR_WIDTH-1:0] WR_addr_out,
   output logic                          WR_en_out
);

   localparam int SHW = shamt_width(DATAPATH_WIDTH);

   logic [DATAPATH_WIDTH-1:0] w_op_a;
   logic [DATAPATH_WIDTH-1:0] w_op_b;
   logic [DATAPATH_WIDTH-1:0] w_alu;
   logic [DATAPATH_WIDTH-1:0] w_product;
   logic [SHW-1:0]            w_shamt;
   logic                      w_stall;
   logic                      w_mul_done;

   // Operand A: own output register beats write-back; r0 is never forwarded.
   always_comb begin
      w_op_a = R1_data_in;
      if (R1_addr_in != '0 && WR_en_out && WR_addr_out == R1_addr_in) begin
         w_op_a = result_out;
      end else if (R1_addr_in != '0 && wb_wr_en && wb_wr_addr == R1_addr_in) begin
         w_op_a = wb_wr_data;
      end
   end

   // Operand B: same priority as operand A.
   always_comb begin
      w_op_b = R2_data_in;
      if (R2_addr_in != '0 && WR_en_out && WR_addr_out == R2_addr_in) begin
         w_op_b = result_out;
      end else if (R2_addr_in != '0 && wb_wr_en && wb_wr_addr == R2_addr_in) begin
         w_op_b = wb_wr_data;
      end
   end

   assign w_shamt = w_op_b[SHW-1:0];

   // Single-cycle ALU; MUL and reserved opcodes fall through to zero here.
   always_comb begin
      w_alu = '0;
      case (alu_ctrl_in)
         ALU_ADD:  w_alu = w_op_a + w_op_b;
         ALU_SUB:  w_alu = w_op_a - w_op_b;
         ALU_AND:  w_alu = w_op_a & w_op_b;
         ALU_OR:   w_alu = w_op_a | w_op_b;
         ALU_XOR:  w_alu = w_op_a ^ w_op_b;
         ALU_NOT:  w_alu = ~w_op_a;
         ALU_SLL:  w_alu = w_op_a << w_shamt;
         ALU_SRL:  w_alu = w_op_a >> w_shamt;
         ALU_SRA:  w_alu = $signed(w_op_a) >>> w_shamt;
         ALU_SLT:  w_alu = {{(DATAPATH_WIDTH-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
         ALU_SLTU: w_alu = {{(DATAPATH_WIDTH-1){1'b0}}, (w_op_a < w_op_b)};
         ALU_PASS: w_alu = w_op_a;
         default:  w_alu = '0;
      endcase
   end

`ifdef EXEC_MUL_EN
   logic w_mul_busy;
   logic w_mul_start;

   // Start only from IDLE; in DONE the held MUL op must not restart.
   assign w_mul_start = !w_mul_busy && !w_mul_done && (alu_ctrl_in == ALU_MUL) && !flush;
   assign w_stall     = w_mul_start || w_mul_busy;

   mul_iter #(
      .WIDTH (DATAPATH_WIDTH)
   ) u_mul_iter (
      .clk       (clk),
      .reset     (reset),
      .i_start   (w_mul_start),
      .i_abort   (flush),
      .i_a       (w_op_a),
      .i_b       (w_op_b),
      .o_busy    (w_mul_busy),
      .o_done    (w_mul_done),
      .o_product (w_product)
   );
`else
   assign w_stall    = 1'b0;
   assign w_mul_done = 1'b0;
   assign w_product  = '0;
`endif

   assign stall_out = w_stall;

   // Output register: flush or stall inserts a bubble and holds the rest.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_out      <= '0;
         result_out  <= '0;
         WR_addr_out <= '0;
         WR_en_out   <= 1'b0;
      end else if (flush || w_stall) begin
         WR_en_out <= 1'b0;
      end else begin
         pc_out      <= pc_in;
         result_out  <= w_mul_done ? w_product : w_alu;
         WR_addr_out <= WR_addr_in;
         WR_en_out   <= WR_en_in;
      end
   end

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

   logic        clk;
   logic        reset;
   logic        flush;
   logic [8:0]  pc_in;
   logic [63:0] R1_data_in, R2_data_in;
   logic [4:0]  R1_addr_in, R2_addr_in, WR_addr_in;
   logic        WR_en_in;
   logic [3:0]  alu_ctrl_in;
   logic        wb_wr_en;
   logic [4:0]  wb_wr_addr;
   logic [63:0] wb_wr_data;
   logic        stall_out;
   logic [8:0]  pc_out;
   logic [63:0] result_out;
   logic [4:0]  WR_addr_out;
   logic        WR_en_out;

   int vecs = 0;
   int errs = 0;

   execute_stage #(
      .DATAPATH_WIDTH     (64),
      .REGFILE_ADDR_WIDTH (5),
      .INST_ADDR_WIDTH    (9)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .pc_in       (pc_in),
      .R1_data_in  (R1_data_in),
      .R2_data_in  (R2_data_in),
      .R1_addr_in  (R1_addr_in),
      .R2_addr_in  (R2_addr_in),
      .WR_addr_in  (WR_addr_in),
      .WR_en_in    (WR_en_in),
      .alu_ctrl_in (alu_ctrl_in),
      .wb_wr_en    (wb_wr_en),
      .wb_wr_addr  (wb_wr_addr),
      .wb_wr_data  (wb_wr_data),
      .stall_out   (stall_out),
      .pc_out      (pc_out),
      .result_out  (result_out),
      .WR_addr_out (WR_addr_out),
      .WR_en_out   (WR_en_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic [8:0] pc, input logic [3:0] op,
                         input logic [4:0] a1, input logic [63:0] d1,
                         input logic [4:0] a2, input logic [63:0] d2,
                         input logic [4:0] wa, input logic we);
      pc_in       = pc;
      alu_ctrl_in = op;
      R1_addr_in  = a1;
      R1_data_in  = d1;
      R2_addr_in  = a2;
      R2_data_in  = d2;
      WR_addr_in  = wa;
      WR_en_in    = we;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      flush = 1'b1;
      set_op(9'd5, 4'd0, 5'd0, 64'd3, 5'd0, 64'd4, 5'd6, 1'b1);
      step();
      vecs++; if (pc_out !== 9'd0) begin errs++; $display("FAIL reset_pc got=%0h exp=0", pc_out); end
      vecs++; if (result_out !== 64'd0) begin errs++; $display("FAIL reset_result got=%0h exp=0", result_out); end
      vecs++; if (WR_addr_out !== 5'd0) begin errs++; $display("FAIL reset_wraddr got=%0h exp=0", WR_addr_out); end
      vecs++; if (WR_en_out !== 1'b0) begin errs++; $display("FAIL reset_wren got=%0b exp=0", WR_en_out); end
      vecs++; if (stall_out !== 1'b0) begin errs++; $display("FAIL reset_stall got=%0b exp=0", stall_out); end
      reset = 1'b0;
      flush = 1'b0;
      set_op(9'd7, 4'd0, 5'd0, 64'd1, 5'd0, 64'd1, 5'd2, 1'b1);
      step();
      vecs++; if (result_out !== 64'd2) begin errs++; $display("FAIL reset_then_add got=%0h exp=2", result_out); end
      vecs++; if (WR_en_out !== 1'b1) begin errs++; $display("FAIL reset_then_add_en got=%0b exp=1", WR_en_out); end
   endtask

   task automatic test_add();
      set_op(9'd10, 4'd0, 5'd0, 64'd5, 5'd0, 64'd7, 5'd3, 1'b1);
      step();
      vecs++; if (result_out !== 64'd12) begin errs++; $display("FAIL add_result got=%0h exp=c", result_out); end
      vecs++; if (WR_addr_out !== 5'd3) begin errs++; $display("FAIL add_wraddr got=%0h exp=3", WR_addr_out); end
      vecs++; if (WR_en_out !== 1'b1) begin errs++; $display("FAIL add_wren got=%0b exp=1", WR_en_out); end
      vecs++; if (pc_out !== 9'd10) begin errs++; $display("FAIL add_pc got=%0h exp=a", pc_out); end
   endtask

   task automatic test_forwarding();
      // r4 = 60 + 40
      set_op(9'd20, 4'd0, 5'd1, 64'd60, 5'd2, 64'd40, 5'd4, 1'b1);
      step();
      vecs++; if (result_out !== 64'd100) begin errs++; $display("FAIL fwd_setup got=%0d exp=100", result_out); end
      // SUB r4,r4: stale regfile 55, wb also writing r4=9; EX value must win
      set_op(9'd21, 4'd1, 5'd4, 64'd55, 5'd4, 64'd55, 5'd5, 1'b1);
      wb_wr_en = 1'b1; wb_wr_addr = 5'd4; wb_wr_data = 64'd9;
      vecs++; if (stall_out !== 1'b0) begin errs++; $display("FAIL fwd_nostall got=%0b exp=0", stall_out); end
      step();
      vecs++; if (result_out !== 64'd0) begin errs++; $display("FAIL fwd_ex_priority got=%0d exp=0", result_out); end
      // ADD r6 + r7: r6 from wb (20), r7 from regfile (3)
      set_op(9'd22, 4'd0, 5'd6, 64'd111, 5'd7, 64'd3, 5'd8, 1'b1);
      wb_wr_en = 1'b1; wb_wr_addr = 5'd6; wb_wr_data = 64'd20;
      step();
      vecs++; if (result_out !== 64'd23) begin errs++; $display("FAIL fwd_wb got=%0d exp=23", result_out); end
      // ADD r8 + r1: r8 from own output (23), r1 regfile 2
      set_op(9'd23, 4'd0, 5'd8, 64'd0, 5'd1, 64'd2, 5'd0, 1'b1);
      wb_wr_en = 1'b0;
      step();
      vecs++; if (result_out !== 64'd25) begin errs++; $display("FAIL fwd_ex_b2b got=%0d exp=25", result_out); end
      // last op wrote "r0"=25; r0 must not forward from EX or wb
      set_op(9'd24, 4'd0, 5'd0, 64'd0, 5'd0, 64'd0, 5'd9, 1'b1);
      wb_wr_en = 1'b1; wb_wr_addr = 5'd0; wb_wr_data = 64'd5;
      step();
      vecs++; if (result_out !== 64'd0) begin errs++; $display("FAIL fwd_r0 got=%0d exp=0", result_out); end
      wb_wr_en = 1'b0; wb_wr_addr = 5'd0; wb_wr_data = 64'd0;
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp;
   } vec_t;

   task automatic test_alu();
      vec_t tv[16];
      tv[0]  = '{4'd1,  64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE};
      tv[1]  = '{4'd0,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1};
      tv[2]  = '{4'd2,  64'hF0F0, 64'hFF00, 64'hF000};
      tv[3]  = '{4'd3,  64'hF0F0, 64'h0F0F, 64'hFFFF};
      tv[4]  = '{4'd4,  64'hFF00, 64'h0FF0, 64'hF0F0};
      tv[5]  = '{4'd5,  64'h0F, 64'd0, 64'hFFFF_FFFF_FFFF_FFF0};
      tv[6]  = '{4'd6,  64'd1, 64'd63, 64'h8000_0000_0000_0000};
      tv[7]  = '{4'd6,  64'd1, 64'd65, 64'd2};
      tv[8]  = '{4'd7,  64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000};
      tv[9]  = '{4'd8,  64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000};
      tv[10] = '{4'd9,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1};
      tv[11] = '{4'd10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0};
      tv[12] = '{4'd9,  64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
      tv[13] = '{4'd10, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1};
      tv[14] = '{4'd11, 64'h1234, 64'd99, 64'h1234};
      tv[15] = '{4'd13, 64'd5, 64'd6, 64'd0};
      for (int i = 0; i < 16; i++) begin
         set_op(9'(40 + i), tv[i].op, 5'd0, tv[i].a, 5'd0, tv[i].b, 5'd9, 1'b1);
         vecs++; if (stall_out !== 1'b0) begin errs++; $display("FAIL alu_stall[%0d] got=%0b exp=0", i, stall_out); end
         step();
         vecs++; if (result_out !== tv[i].exp) begin errs++; $display("FAIL alu[%0d] op=%0d got=%0h exp=%0h", i, tv[i].op, result_out, tv[i].exp); end
         vecs++; if (WR_en_out !== 1'b1) begin errs++; $display("FAIL alu_wren[%0d] got=%0b exp=1", i, WR_en_out); end
      end
      set_op(9'd60, 4'd15, 5'd0, 64'hAB, 5'd0, 64'hCD, 5'd11, 1'b1);
      step();
      vecs++; if (result_out !== 64'd0 || WR_addr_out !== 5'd11) begin errs++; $display("FAIL alu_rsvd15 got=%0h/%0d exp=0/11", result_out, WR_addr_out); end
   endtask

   task automatic test_flush();
      set_op(9'd70, 4'd0, 5'd0, 64'd2, 5'd0, 64'd3, 5'd12, 1'b1);
      step();
      vecs++; if (result_out !== 64'd5) begin errs++; $display("FAIL flush_setup got=%0d exp=5", result_out); end
      set_op(9'd71, 4'd0, 5'd0, 64'd10, 5'd0, 64'd10, 5'd13, 1'b1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      vecs++; if (WR_en_out !== 1'b0) begin errs++; $display("FAIL flush_bubble got=%0b exp=0", WR_en_out); end
      vecs++; if (result_out !== 64'd5 || pc_out !== 9'd70) begin errs++; $display("FAIL flush_hold got=%0d/%0d exp=5/70", result_out, pc_out); end
      step();
      vecs++; if (result_out !== 64'd20 || WR_en_out !== 1'b1) begin errs++; $display("FAIL flush_resume got=%0d/%0b exp=20/1", result_out, WR_en_out); end
   endtask

`ifdef EXEC_MUL_EN
   task automatic test_mul();
      int n;
      n = 0;
      set_op(9'd80, 4'd12, 5'd0, 64'd7, 5'd0, 64'd6, 5'd14, 1'b1);
      while (stall_out === 1'b1 && n < 200) begin
         vecs++; if (WR_en_out !== 1'b0) begin errs++; $display("FAIL mul_bubble[%0d] got=%0b exp=0", n, WR_en_out); end
         n++;
         step();
      end
      vecs++; if (n !== 65) begin errs++; $display("FAIL mul_stall_cycles got=%0d exp=65", n); end
      step();
      vecs++; if (result_out !== 64'd42) begin errs++; $display("FAIL mul_result got=%0d exp=42", result_out); end
      vecs++; if (WR_en_out !== 1'b1 || WR_addr_out !== 5'd14 || pc_out !== 9'd80) begin errs++; $display("FAIL mul_ctrl got=%0b/%0d/%0d exp=1/14/80", WR_en_out, WR_addr_out, pc_out); end
      set_op(9'd81, 4'd0, 5'd0, 64'd1, 5'd0, 64'd2, 5'd1, 1'b0);
      vecs++; if (stall_out !== 1'b0) begin errs++; $display("FAIL mul_after_stall got=%0b exp=0", stall_out); end
   endtask

   task automatic test_mul_flush();
      set_op(9'd90, 4'd12, 5'd0, 64'd7, 5'd0, 64'd6, 5'd15, 1'b1);
      for (int i = 0; i < 11; i++) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      set_op(9'd91, 4'd0, 5'd0, 64'd1, 5'd0, 64'd1, 5'd1, 1'b0);
      vecs++; if (stall_out !== 1'b0) begin errs++; $display("FAIL mulflush_stall got=%0b exp=0", stall_out); end
      vecs++; if (WR_en_out !== 1'b0) begin errs++; $display("FAIL mulflush_bubble got=%0b exp=0", WR_en_out); end
      for (int i = 0; i < 70; i++) begin
         step();
         if (stall_out !== 1'b0 || WR_en_out !== 1'b0 || result_out === 64'd42) begin
            vecs++; errs++;
            $display("FAIL mulflush_residue cyc=%0d got stall=%0b en=%0b res=%0d exp 0/0/not42", i, stall_out, WR_en_out, result_out);
            break;
         end
      end
      vecs++; if (result_out !== 64'd2) begin errs++; $display("FAIL mulflush_result got=%0d exp=2", result_out); end
   endtask

   task automatic test_reset_mid_mul();
      set_op(9'd100, 4'd12, 5'd0, 64'd3, 5'd0, 64'd3, 5'd16, 1'b1);
      for (int i = 0; i < 20; i++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      set_op(9'd101, 4'd0, 5'd0, 64'd1, 5'd0, 64'd1, 5'd2, 1'b1);
      vecs++; if (stall_out !== 1'b0) begin errs++; $display("FAIL rstmul_stall got=%0b exp=0", stall_out); end
      vecs++; if (pc_out !== 9'd0 || result_out !== 64'd0 || WR_addr_out !== 5'd0 || WR_en_out !== 1'b0) begin errs++; $display("FAIL rstmul_outputs got=%0d/%0d/%0d/%0b exp=0/0/0/0", pc_out, result_out, WR_addr_out, WR_en_out); end
      step();
      vecs++; if (result_out !== 64'd2 || WR_en_out !== 1'b1) begin errs++; $display("FAIL rstmul_add got=%0d/%0b exp=2/1", result_out, WR_en_out); end
   endtask
`else
   task automatic test_mul();
      set_op(9'd80, 4'd12, 5'd0, 64'd7, 5'd0, 64'd6, 5'd14, 1'b1);
      vecs++; if (stall_out !== 1'b0) begin errs++; $display("FAIL mul_off_stall got=%0b exp=0", stall_out); end
      step();
      vecs++; if (result_out !== 64'd0) begin errs++; $display("FAIL mul_off_result got=%0d exp=0", result_out); end
      vecs++; if (WR_en_out !== 1'b1 || WR_addr_out !== 5'd14) begin errs++; $display("FAIL mul_off_ctrl got=%0b/%0d exp=1/14", WR_en_out, WR_addr_out); end
   endtask
`endif

   initial begin
      reset      = 1'b1;
      flush      = 1'b0;
      wb_wr_en   = 1'b0;
      wb_wr_addr = 5'd0;
      wb_wr_data = 64'd0;
      set_op(9'd0, 4'd0, 5'd0, 64'd0, 5'd0, 64'd0, 5'd0, 1'b0);
      test_reset();
      test_add();
      test_forwarding();
      test_alu();
      test_flush();
      test_mul();
`ifdef EXEC_MUL_EN
      test_mul_flush();
      test_reset_mid_mul();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
